// File: rtl/serial_paralelo_sync_pkg.sv
// Shared constants and FSM encoding for the serial-to-parallel byte aligner.
// The optional com_count output is controlled by the COM_COUNT_EN macro in the top module.
package serial_paralelo_sync_pkg;

    localparam logic [7:0] COM_CHAR        = 8'hBC;
    localparam logic [7:0] IDLE_CHAR       = 8'h7C;
    localparam int         COM_REQ_DEFAULT = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    // A byte is payload unless it is one of the two control characters.
    function automatic logic is_payload(input logic [7:0] b,
                                        input logic [7:0] com,
                                        input logic [7:0] idle);
        return (b != com) && (b != idle);
    endfunction

endpackage

// File: rtl/serial_paralelo_sync_shift8.sv
// Serial shift register and 3-bit byte-phase counter for serial_paralelo_sync.
// The candidate byte combines the stored history with the bit arriving on this edge.
module serial_shift8 (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_in,
    input  logic       clr,
    output logic [7:0] cand,
    output logic       byte_done
);

    // Only seven stored bits are ever observed; the eighth would fall off unread.
    logic [6:0] hist;
    logic [2:0] bit_cnt;

    assign cand      = {hist, data_in};
    assign byte_done = (bit_cnt == 3'd7);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            hist    <= '0;
            bit_cnt <= '0;
        end else begin
            hist    <= cand[6:0];
            bit_cnt <= clr ? 3'd0 : bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/serial_paralelo_sync.sv
// Byte aligner: locks onto COM characters, goes active after COM_REQ in a row, then emits bytes.
// Define COM_COUNT_EN to add the saturating com_count output.
module serial_paralelo_sync
    import serial_paralelo_sync_pkg::*;
#(
    parameter int         WIDTH   = 8,
    parameter logic [7:0] COM     = COM_CHAR,
    parameter logic [7:0] IDLE    = IDLE_CHAR,
    parameter int         COM_REQ = COM_REQ_DEFAULT
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
`ifdef COM_COUNT_EN
    output logic [7:0]       com_count,
`endif
    output logic             active
);

    localparam logic [3:0] COM_REQ_C = 4'(COM_REQ);

    state_t           state, state_n;
    logic [3:0]       com_cnt, com_cnt_n;
    logic [WIDTH-1:0] data_n;
    logic             valid_n;
    logic             clr;
    logic [7:0]       cand;
    logic             byte_done;
    logic             is_com;

    serial_shift8 u_shift (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .data_in   (data_in),
        .clr       (clr),
        .cand      (cand),
        .byte_done (byte_done)
    );

    assign is_com = (cand == COM);
    assign active = (state == ACTIVE);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        com_cnt_n = com_cnt;
        data_n    = data_out;
        valid_n   = valid_out;
        clr       = 1'b0;
        unique case (state)
            SEARCH: begin
                // Holding the phase counter at zero makes a match edge the byte boundary.
                clr = 1'b1;
                if (is_com) begin
                    com_cnt_n = 4'd1;
                    state_n   = SYNC;
                end
            end
            SYNC: begin
                if (byte_done) begin
                    if (is_com) begin
                        com_cnt_n = com_cnt + 4'd1;
                        if (com_cnt_n == COM_REQ_C) state_n = ACTIVE;
                    end else begin
                        com_cnt_n = 4'd0;
                        state_n   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (byte_done) begin
                    data_n  = cand;
                    valid_n = is_payload(cand, COM, IDLE);
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            com_cnt   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            state     <= state_n;
            com_cnt   <= com_cnt_n;
            data_out  <= data_n;
            valid_out <= valid_n;
        end
    end

`ifdef COM_COUNT_EN
    // Only COMs completed after the link is up are counted; the locking run is not.
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            com_count <= '0;
        end else if (active && byte_done && is_com && com_count != 8'hFF) begin
            com_count <= com_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// Scoreboard bench for serial_paralelo_sync: stimulus queues expected output changes
// with the clock edge that must produce them; an independent monitor checks each change.
module tb_serial_paralelo_sync;

    typedef struct {
        int unsigned edge_no;
        logic [9:0]  outs;     // {active, valid_out, data_out}
    } exp_t;

    logic       clk_8f = 1'b0;
    logic       reset  = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
`ifdef COM_COUNT_EN
    logic [7:0] com_count;
`endif

    int unsigned edge_no = 0;
    int          n_checks = 0;
    int          n_fails  = 0;
    exp_t        exp_q[$];
    logic [9:0]  exp_cur = '0;

    serial_paralelo_sync dut (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
`ifdef COM_COUNT_EN
        .com_count (com_count),
`endif
        .active    (active)
    );

    always #5 clk_8f = ~clk_8f;

    always @(posedge clk_8f) edge_no <= edge_no + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, actual, expected, edge_no);
        end
    endtask

    function automatic logic [9:0] tup(input logic a, input logic v, input logic [7:0] d);
        return {a, v, d};
    endfunction

    task automatic expect_change(input int unsigned at_edge, input logic [9:0] outs);
        exp_t e;
        if (outs != exp_cur) begin
            e.edge_no = at_edge;
            e.outs    = outs;
            exp_q.push_back(e);
            exp_cur = outs;
        end
    endtask

    // Sends one byte MSB first; an expectation, if any, is tied to the edge sampling bit 0.
    task automatic send_byte(input logic [7:0] b, input logic has_exp, input logic [9:0] outs);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk_8f);
            if (i == 0 && has_exp) expect_change(edge_no + 1, outs);
            data_in = b[i];
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_8f);
        data_in = b;
    endtask

    // Called just after a negedge; outputs must drop at once, the monitor sees it next negedge.
    task automatic pulse_reset();
        #2;
        expect_change(edge_no + 1, '0);
        reset = 1'b0;
        #1;
        check("reset_async", {active, valid_out, data_out}, 10'h000);
        repeat (2) @(negedge clk_8f);
        data_in = 1'b0;
        reset   = 1'b1;
    endtask

    // Monitor: every change of the output tuple must match the oldest queued expectation.
    initial begin
        logic [9:0] prev, cur;
        exp_t       e;
        @(negedge clk_8f);
        prev = {active, valid_out, data_out};
        forever begin
            @(negedge clk_8f);
            cur = {active, valid_out, data_out};
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_change", 32'(cur), 32'(prev));
                end else begin
                    e = exp_q.pop_front();
                    check("out_edge", e.edge_no == edge_no ? edge_no : edge_no, e.edge_no);
                    check("out_value", 32'(cur), 32'(e.outs));
                end
                prev = cur;
            end
        end
    end

    initial begin
        // Reset held with toggling input: everything stays at zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_8f);
            data_in = ~data_in;
            check("reset_hold", {active, valid_out, data_out}, 10'h000);
        end
        @(negedge clk_8f);
        data_in = 1'b0;
        reset   = 1'b1;

        // Alignment after three stray bits.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (3) send_byte(8'hBC, 1'b0, '0);
        send_byte(8'hBC, 1'b1, tup(1'b1, 1'b0, 8'h00));
        send_byte(8'hA5, 1'b1, tup(1'b1, 1'b1, 8'hA5));

        // A broken COM run must not bring the link up.
        @(negedge clk_8f);
        pulse_reset();
        repeat (3) send_byte(8'hBC, 1'b0, '0);
        send_byte(8'h55, 1'b0, '0);
        repeat (3) send_byte(8'hBC, 1'b0, '0);
        send_byte(8'hBC, 1'b1, tup(1'b1, 1'b0, 8'h00));
        send_byte(8'h3C, 1'b1, tup(1'b1, 1'b1, 8'h3C));

        // Control characters are delivered but not flagged valid.
        send_byte(8'hBC, 1'b1, tup(1'b1, 1'b0, 8'hBC));
        send_byte(8'h7C, 1'b1, tup(1'b1, 1'b0, 8'h7C));
        send_byte(8'h12, 1'b1, tup(1'b1, 1'b1, 8'h12));

        // Reset during the fourth bit of F0, then a fresh lock is required.
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clk_8f);
        data_in = 1'b0;
        pulse_reset();
        repeat (3) send_byte(8'hBC, 1'b0, '0);
        send_byte(8'hBC, 1'b1, tup(1'b1, 1'b0, 8'h00));
`ifdef COM_COUNT_EN
        @(negedge clk_8f);
        check("com_count_start", 32'(com_count), 32'h00);
        send_byte(8'h81, 1'b1, tup(1'b1, 1'b1, 8'h81));
        send_byte(8'hBC, 1'b1, tup(1'b1, 1'b0, 8'hBC));
        repeat (9) send_byte(8'hBC, 1'b0, '0);
        @(negedge clk_8f);
        check("com_count_10", 32'(com_count), 32'd10);
        repeat (290) send_byte(8'hBC, 1'b0, '0);
        @(negedge clk_8f);
        check("com_count_sat", 32'(com_count), 32'hFF);
`else
        send_byte(8'h81, 1'b1, tup(1'b1, 1'b1, 8'h81));
`endif

        repeat (3) @(negedge clk_8f);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
